// File: rtl/layer_arbiter.sv
// Frame-synchronous priority mux for five object layers over background, with per-layer blink.
// One registered stage pixel->rgbOut; config held in a one-deep pending slot (cfgReady low while full).
module layer_arbiter #(
   parameter int BLINK_FRAMES = 120,
   parameter int BLINK_HALF   = 8
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic [4:0]  drawReq,
   input  logic [39:0] layerRGB,
   input  logic [7:0]  backGroundRGB,
   input  logic        cfgValid,
   input  logic [14:0] cfgOrder,
   output logic        cfgReady,
   output logic        cfgErr,
   input  logic [4:0]  blinkStart,
   output logic [4:0]  blinking,
   output logic [7:0]  rgbOut,
   output logic [2:0]  winLayer
);

   localparam int RW = $clog2(BLINK_FRAMES + 1);
   localparam int PW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
   localparam logic [RW-1:0] REM_LOAD  = RW'(BLINK_FRAMES);
   localparam logic [PW-1:0] PH_LAST   = PW'(BLINK_HALF - 1);
   localparam logic [14:0]   ORD_RESET = 15'b100_011_010_001_000;

   logic [14:0]   act_ord;
   logic [14:0]   pend_ord;
   logic          pend_valid;
   logic          pend_ok;
   logic [7:0]    seen;
   logic [2:0]    chk_id;
   logic [RW-1:0] remaining [5];
   logic [PW-1:0] phase     [5];
   logic [4:0]    hidden;
   logic [7:0]    eff;
   logic [63:0]   rgb_pad;
   logic [2:0]    sel_id;
   logic [2:0]    sel_win;
   logic [7:0]    sel_rgb;

   assign cfgReady = !pend_valid;
   assign eff      = {3'b000, drawReq & ~hidden};
   assign rgb_pad  = {24'd0, layerRGB};

   always_comb begin
      for (int i = 0; i < 5; i++) begin
         blinking[i] = (remaining[i] != '0);
      end
   end

   // Valid order: every slot holds an id 0..4 and no id repeats.
   always_comb begin
      seen    = '0;
      pend_ok = 1'b1;
      chk_id  = '0;
      for (int k = 0; k < 5; k++) begin
         chk_id = pend_ord[3*k +: 3];
         if (chk_id > 3'd4 || seen[chk_id]) pend_ok = 1'b0;
         seen[chk_id] = 1'b1;
      end
   end

   // Walk from lowest to highest slot so the highest-priority requester is written last.
   always_comb begin
      sel_win = 3'd7;
      sel_rgb = backGroundRGB;
      sel_id  = '0;
      for (int k = 4; k >= 0; k--) begin
         sel_id = act_ord[3*k +: 3];
         if (eff[sel_id]) begin
            sel_win = sel_id;
            sel_rgb = rgb_pad[{sel_id, 3'b000} +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         act_ord    <= ORD_RESET;
         pend_ord   <= '0;
         pend_valid <= 1'b0;
         cfgErr     <= 1'b0;
         rgbOut     <= '0;
         winLayer   <= 3'd7;
      end else begin
         rgbOut   <= sel_rgb;
         winLayer <= sel_win;
         cfgErr   <= startOfFrame && pend_valid && !pend_ok;
         if (startOfFrame && pend_valid) begin
            pend_valid <= 1'b0;
            if (pend_ok) act_ord <= pend_ord;
         end
         // Accepting only when empty means a same-cycle transfer waits for the next frame.
         if (cfgValid && !pend_valid) begin
            pend_ord   <= cfgOrder;
            pend_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         hidden <= '0;
         for (int i = 0; i < 5; i++) begin
            remaining[i] <= '0;
            phase[i]     <= '0;
         end
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (blinkStart[i]) begin
               remaining[i] <= REM_LOAD;
               phase[i]     <= '0;
               hidden[i]    <= 1'b1;
            end else if (startOfFrame && remaining[i] != '0) begin
               remaining[i] <= remaining[i] - RW'(1);
               if (remaining[i] == RW'(1)) begin
                  phase[i]  <= '0;
                  hidden[i] <= 1'b0;
               end else if (phase[i] == PH_LAST) begin
                  phase[i]  <= '0;
                  hidden[i] <= ~hidden[i];
               end else begin
                  phase[i] <= phase[i] + PW'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_layer_arbiter.sv
// Directed bench for layer_arbiter: expected pixels queued at drive time, compared one cycle later.
module tb_layer_arbiter;

   logic        clk = 1'b0;
   logic        resetN;
   logic        startOfFrame;
   logic [4:0]  drawReq;
   logic [39:0] layerRGB;
   logic [7:0]  backGroundRGB;
   logic        cfgValid;
   logic [14:0] cfgOrder;
   logic        cfgReady;
   logic        cfgErr;
   logic [4:0]  blinkStart;
   logic [4:0]  blinking;
   logic [7:0]  rgbOut;
   logic [2:0]  winLayer;

   int checks = 0;
   int errors = 0;
   logic [10:0] exp_q [$];

   layer_arbiter #(.BLINK_FRAMES(4), .BLINK_HALF(2)) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .drawReq(drawReq),
      .layerRGB(layerRGB), .backGroundRGB(backGroundRGB), .cfgValid(cfgValid),
      .cfgOrder(cfgOrder), .cfgReady(cfgReady), .cfgErr(cfgErr), .blinkStart(blinkStart),
      .blinking(blinking), .rgbOut(rgbOut), .winLayer(winLayer)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rgb_of(input logic [2:0] w);
      logic [7:0] layer_col [5];
      layer_col = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      return (w == 3'd7) ? backGroundRGB : layer_col[w];
   endfunction

   // One clock with the given requests; pulses set beforehand are dropped afterwards.
   task automatic pix(input string tag, input logic [4:0] req, input logic [2:0] exp_win);
      logic [10:0] e;
      drawReq = req;
      exp_q.push_back({exp_win, rgb_of(exp_win)});
      @(posedge clk);
      #1;
      startOfFrame = 1'b0;
      cfgValid     = 1'b0;
      blinkStart   = '0;
      e = exp_q.pop_front();
      chk({tag, ".win"}, {13'd0, winLayer}, {13'd0, e[10:8]});
      chk({tag, ".rgb"}, {8'd0, rgbOut}, {8'd0, e[7:0]});
   endtask

   initial begin
      resetN        = 1'b0;
      startOfFrame  = 1'b0;
      drawReq       = 5'h1f;
      layerRGB      = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
      backGroundRGB = 8'h25;
      cfgValid      = 1'b0;
      cfgOrder      = '0;
      blinkStart    = '0;

      #23;
      chk("rst.rgb", {8'd0, rgbOut}, 16'h0);
      chk("rst.win", {13'd0, winLayer}, 16'd7);
      chk("rst.rdy", {15'd0, cfgReady}, 16'd1);
      chk("rst.err", {15'd0, cfgErr}, 16'd0);
      chk("rst.blink", {11'd0, blinking}, 16'd0);
      resetN = 1'b1;
      pix("post_rst", 5'h1f, 3'd0);

      pix("prio_tank1", 5'b11010, 3'd1);
      pix("prio_tank2", 5'b11000, 3'd3);
      pix("bg", 5'b00000, 3'd7);

      // Reverse the order mid-frame; it must wait for startOfFrame.
      cfgValid = 1'b1;
      cfgOrder = 15'b000_001_010_011_100;
      pix("cfg_xfer", 5'h1f, 3'd0);
      chk("cfg_busy", {15'd0, cfgReady}, 16'd0);
      pix("cfg_hold", 5'h1f, 3'd0);
      startOfFrame = 1'b1;
      pix("cfg_sof", 5'h1f, 3'd0);
      chk("cfg_rdy", {15'd0, cfgReady}, 16'd1);
      chk("cfg_noerr", {15'd0, cfgErr}, 16'd0);
      pix("cfg_new", 5'h1f, 3'd4);
      pix("cfg_new2", 5'b00011, 3'd1);

      // Offer arriving on a startOfFrame cycle lands one frame later.
      cfgValid     = 1'b1;
      cfgOrder     = 15'b100_011_010_001_000;
      startOfFrame = 1'b1;
      pix("sim_sof", 5'h1f, 3'd4);
      chk("sim_busy", {15'd0, cfgReady}, 16'd0);
      pix("sim_held", 5'h1f, 3'd4);
      startOfFrame = 1'b1;
      pix("sim_sof2", 5'h1f, 3'd4);
      pix("sim_applied", 5'h1f, 3'd0);

      // Duplicate id 3 must be rejected with a single cfgErr pulse.
      cfgValid = 1'b1;
      cfgOrder = 15'b011_011_010_001_000;
      pix("bad_xfer", 5'h1f, 3'd0);
      startOfFrame = 1'b1;
      pix("bad_sof", 5'h1f, 3'd0);
      chk("bad_err", {15'd0, cfgErr}, 16'd1);
      chk("bad_rdy", {15'd0, cfgReady}, 16'd1);
      pix("bad_keep", 5'b11000, 3'd3);
      chk("bad_err_once", {15'd0, cfgErr}, 16'd0);

      // Blink on tank1: hidden two frames, visible two frames, then done.
      blinkStart = 5'b00010;
      pix("blk_start", 5'b00010, 3'd1);
      chk("blk_on", {11'd0, blinking}, 16'b00010);
      pix("blk_f0", 5'b00010, 3'd7);
      pix("blk_f0_other", 5'b00110, 3'd2);
      startOfFrame = 1'b1;
      pix("blk_sof1", 5'b00010, 3'd7);
      pix("blk_f1", 5'b00010, 3'd7);
      startOfFrame = 1'b1;
      pix("blk_sof2", 5'b00010, 3'd7);
      pix("blk_f2", 5'b00010, 3'd1);
      startOfFrame = 1'b1;
      pix("blk_sof3", 5'b00010, 3'd1);
      pix("blk_f3", 5'b00010, 3'd1);
      chk("blk_still", {11'd0, blinking}, 16'b00010);
      startOfFrame = 1'b1;
      pix("blk_sof4", 5'b00010, 3'd1);
      chk("blk_done", {11'd0, blinking}, 16'd0);
      pix("blk_after", 5'b00010, 3'd1);

      // Restart mid-sequence reloads the full four-frame count.
      blinkStart = 5'b00010;
      pix("rs_start", 5'b00010, 3'd1);
      startOfFrame = 1'b1;
      pix("rs_sof1", 5'b00010, 3'd7);
      startOfFrame = 1'b1;
      pix("rs_sof2", 5'b00010, 3'd7);
      pix("rs_vis", 5'b00010, 3'd1);
      blinkStart = 5'b00010;
      pix("rs_restart", 5'b00010, 3'd1);
      pix("rs_hidden", 5'b00010, 3'd7);
      for (int f = 1; f <= 4; f++) begin
         startOfFrame = 1'b1;
         pix("rs_step", 5'b00010, (f <= 2) ? 3'd7 : 3'd1);
         chk("rs_blinking", {11'd0, blinking}, (f < 4) ? 16'b00010 : 16'd0);
      end

      // Asynchronous reset mid-handshake and mid-blink clears everything at once.
      blinkStart = 5'b00001;
      cfgValid   = 1'b1;
      cfgOrder   = 15'b000_001_010_011_100;
      pix("ar_setup", 5'h1f, 3'd0);
      chk("ar_pend", {15'd0, cfgReady}, 16'd0);
      #2;
      resetN = 1'b0;
      #1;
      chk("ar_rdy", {15'd0, cfgReady}, 16'd1);
      chk("ar_blink", {11'd0, blinking}, 16'd0);
      chk("ar_win", {13'd0, winLayer}, 16'd7);
      chk("ar_rgb", {8'd0, rgbOut}, 16'h0);
      #4;
      resetN = 1'b1;
      startOfFrame = 1'b1;
      pix("ar_sof", 5'h1f, 3'd0);
      pix("ar_order_kept", 5'h1f, 3'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
